// File: rtl/dmac_pkg.sv
// Shared DMA controller types: command descriptor and AXI field widths.
package dmac_pkg;

  localparam int unsigned DMAC_ADDR_WD = 32;
  localparam int unsigned BURST_BITS   = 2;
  localparam int unsigned SIZE_BITS    = 3;

  typedef struct packed {
    logic [DMAC_ADDR_WD-1:0] src_addr;
    logic [DMAC_ADDR_WD-1:0] dst_addr;
    logic [DMAC_ADDR_WD-1:0] len;
    logic [BURST_BITS-1:0]   burst;
    logic [SIZE_BITS-1:0]    size;
  } dmac_cmd_t;

  typedef enum logic [0:0] {StIdle, StHold} arb_state_e;

endpackage

// File: rtl/dmac_cmd_arbiter_if.sv
// Requester, controller-command and completion signals of the command arbiter.
interface dmac_cmd_arbiter_if #(
  parameter int unsigned ADDR_WD         = 32,
  parameter int unsigned CHANNEL_COUNT   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned CH_WD  = $clog2(CHANNEL_COUNT);
  localparam int unsigned OUT_WD = $clog2(MAX_OUTSTANDING) + 1;

  logic [CHANNEL_COUNT-1:0]              req_valid;
  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0] req_src_addr;
  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0] req_dst_addr;
  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0] req_len;
  logic [CHANNEL_COUNT-1:0][1:0]         req_burst;
  logic [CHANNEL_COUNT-1:0][2:0]         req_size;
  logic [CHANNEL_COUNT-1:0]              req_ready;
  logic [CHANNEL_COUNT-1:0]              ch_enable;

  logic               cmd_valid;
  logic [ADDR_WD-1:0] cmd_src_addr;
  logic [ADDR_WD-1:0] cmd_dst_addr;
  logic [ADDR_WD-1:0] cmd_len;
  logic [1:0]         cmd_burst;
  logic [2:0]         cmd_size;
  logic [CH_WD-1:0]   cmd_channel;
  logic               cmd_ready;

  logic              xfer_done;
  logic              done_valid;
  logic [CH_WD-1:0]  done_channel;
  logic [OUT_WD-1:0] outstanding;
  logic              err_spurious;

  modport master (
    input  req_valid, req_src_addr, req_dst_addr, req_len, req_burst, req_size, ch_enable,
    input  cmd_ready, xfer_done,
    output req_ready, cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size,
    output cmd_channel, done_valid, done_channel, outstanding, err_spurious
  );

  modport slave (
    output req_valid, req_src_addr, req_dst_addr, req_len, req_burst, req_size, ch_enable,
    output cmd_ready, xfer_done,
    input  req_ready, cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size,
    input  cmd_channel, done_valid, done_channel, outstanding, err_spurious
  );

endinterface

// File: rtl/dmac_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances when en_i strobes.
module dmac_rr_arbiter #(
  parameter int unsigned CHANNEL_COUNT = 8,
  localparam int unsigned CH_WD        = $clog2(CHANNEL_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNEL_COUNT-1:0] req_i,
  input  logic                     en_i,
  output logic [CHANNEL_COUNT-1:0] gnt_o,
  output logic [CH_WD-1:0]         gnt_idx_o
);

  logic [CH_WD-1:0] last_q, last_d;
  logic             found;
  int unsigned      cand;

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= CHANNEL_COUNT; off++) begin
      cand = (32'(last_q) + off) % CHANNEL_COUNT;
      if (!found && req_i[cand[CH_WD-1:0]]) begin
        found                    = 1'b1;
        gnt_o[cand[CH_WD-1:0]]   = 1'b1;
        gnt_idx_o                = cand[CH_WD-1:0];
      end
    end
    last_d = (en_i && found) ? gnt_idx_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= CH_WD'(CHANNEL_COUNT - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmac_cmd_arbiter.sv
// Shares the DMA command port among requesters and routes completions back via a tag FIFO.
module dmac_cmd_arbiter
  import dmac_pkg::*;
#(
  parameter int unsigned ADDR_WD         = 32,
  parameter int unsigned CHANNEL_COUNT   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic         clk,
  input logic         rst,
  dmac_cmd_arbiter_if.master bus
);

  localparam int unsigned CH_WD  = $clog2(CHANNEL_COUNT);
  localparam int unsigned PTR_WD = $clog2(MAX_OUTSTANDING);
  localparam int unsigned OUT_WD = PTR_WD + 1;

  arb_state_e        state_q;
  dmac_cmd_t         cmd_q;
  logic [CH_WD-1:0]  cmd_ch_q;
  logic [CH_WD-1:0]  tag_q [MAX_OUTSTANDING];
  logic [PTR_WD-1:0] wr_ptr_q, rd_ptr_q;
  logic [OUT_WD-1:0] count_q;
  logic              done_valid_q;
  logic [CH_WD-1:0]  done_ch_q;
  logic              err_q;

  logic                     full, can_grant, push, pop;
  logic [CHANNEL_COUNT-1:0] arb_req, gnt;
  logic [CH_WD-1:0]         gnt_idx;

  assign full      = (count_q == OUT_WD'(MAX_OUTSTANDING));
  assign can_grant = (state_q == StIdle) && !full;
  assign arb_req   = can_grant ? (bus.req_valid & bus.ch_enable) : '0;
  assign push      = (state_q == StHold) && bus.cmd_ready;
  assign pop       = bus.xfer_done && (count_q != '0);

  dmac_rr_arbiter #(
    .CHANNEL_COUNT(CHANNEL_COUNT)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req),
    .en_i     (can_grant),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      cmd_ch_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_valid_q <= 1'b0;
      done_ch_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt != '0) begin
            state_q        <= StHold;
            cmd_ch_q       <= gnt_idx;
            cmd_q.src_addr <= DMAC_ADDR_WD'(bus.req_src_addr[gnt_idx]);
            cmd_q.dst_addr <= DMAC_ADDR_WD'(bus.req_dst_addr[gnt_idx]);
            cmd_q.len      <= DMAC_ADDR_WD'(bus.req_len[gnt_idx]);
            cmd_q.burst    <= bus.req_burst[gnt_idx];
            cmd_q.size     <= bus.req_size[gnt_idx];
          end
        end
        StHold: begin
          if (bus.cmd_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      done_valid_q <= pop;
      if (pop) done_ch_q <= tag_q[rd_ptr_q];
      if (bus.xfer_done && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= cmd_ch_q;
  end

  assign bus.req_ready    = gnt;
  assign bus.cmd_valid    = (state_q == StHold);
  assign bus.cmd_src_addr = ADDR_WD'(cmd_q.src_addr);
  assign bus.cmd_dst_addr = ADDR_WD'(cmd_q.dst_addr);
  assign bus.cmd_len      = ADDR_WD'(cmd_q.len);
  assign bus.cmd_burst    = cmd_q.burst;
  assign bus.cmd_size     = cmd_q.size;
  assign bus.cmd_channel  = cmd_ch_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_channel = done_ch_q;
  assign bus.outstanding  = count_q;
  assign bus.err_spurious = err_q;

endmodule
